// File: rtl/counter_sequencer.sv
// counter_sequencer
//   Run/pause/clear controller for the enable-gated ripple counter that feeds
//   the HEX display pair. Converts start/stop/zero commands into a prescaled
//   one-cycle count enable and a one-cycle active-low clear. The counter value
//   is fed back so that one-shot mode can halt at a programmable limit.
//
// Ports
//   clk       : system clock, rising edge
//   clr       : asynchronous active-low reset
//   start     : run request (acts on rising edge)
//   stop      : pause request (acts on rising edge)
//   zero      : clear request (acts on rising edge)
//   one_shot  : 1 = halt at limit, 0 = free-run with wrap
//   limit     : terminal count for one-shot mode
//   count     : current counter value (feedback)
//   cnt_en    : registered one-cycle count enable
//   cnt_clr_n : registered one-cycle active-low counter clear
//   state     : IDLE=00, RUN=01, PAUSE=10, DONE=11
//   done      : high while in DONE
module counter_sequencer #(
  parameter int unsigned TICK_DIV  = 50000000,
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 zero,
  input  logic                 one_shot,
  input  logic [CNT_WIDTH-1:0] limit,
  input  logic [CNT_WIDTH-1:0] count,
  output logic                 cnt_en,
  output logic                 cnt_clr_n,
  output logic [1:0]           state,
  output logic                 done
);

  localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    DONE  = 2'b11
  } state_t;

  state_t        st, st_nxt;
  logic [PW-1:0] ps, ps_nxt;
  logic          en_nxt;

  logic start_q, stop_q, zero_q;
  logic start_rise, stop_rise, zero_rise;

  // Rises are registered so every command reaches the state register two
  // cycles after the input changes; a level held through reset release
  // still produces exactly one rise because the delay flops reset to 0.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
      zero_q     <= 1'b0;
      start_rise <= 1'b0;
      stop_rise  <= 1'b0;
      zero_rise  <= 1'b0;
    end else begin
      start_q    <= start;
      stop_q     <= stop;
      zero_q     <= zero;
      start_rise <= start & ~start_q;
      stop_rise  <= stop & ~stop_q;
      zero_rise  <= zero & ~zero_q;
    end
  end

  // Priority: zero > stop > start > limit reached. The prescaler only
  // advances (and only issues a pulse) on cycles that remain in RUN.
  always_comb begin
    st_nxt = st;
    ps_nxt = ps;
    en_nxt = 1'b0;
    if (zero_rise) begin
      st_nxt = IDLE;
      ps_nxt = '0;
    end else begin
      case (st)
        IDLE: begin
          if (start_rise) begin
            st_nxt = RUN;
            ps_nxt = '0;
          end
        end
        RUN: begin
          if (stop_rise) begin
            st_nxt = PAUSE;
          end else if (one_shot && (count == limit)) begin
            st_nxt = DONE;
          end else if (ps == PS_LAST) begin
            ps_nxt = '0;
            en_nxt = 1'b1;
          end else begin
            ps_nxt = ps + PW'(1);
          end
        end
        PAUSE: begin
          if (start_rise) st_nxt = RUN;
        end
        DONE: begin
          st_nxt = DONE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      st        <= IDLE;
      ps        <= '0;
      cnt_en    <= 1'b0;
      cnt_clr_n <= 1'b0;
    end else begin
      st        <= st_nxt;
      ps        <= ps_nxt;
      cnt_en    <= en_nxt;
      cnt_clr_n <= ~zero_rise;
    end
  end

  assign state = st;
  assign done  = (st == DONE);

endmodule

// File: tb/tb_counter_sequencer.sv
// tb_counter_sequencer
//   Self-checking bench for counter_sequencer with TICK_DIV=4. A behavioural
//   8-bit counter driven by cnt_en/cnt_clr_n supplies the count feedback; a
//   reference model derived from the command rules predicts the outputs.
module tb_counter_sequencer;

  localparam int unsigned TD = 4;
  localparam int unsigned W  = 8;

  logic         clk = 1'b0;
  logic         clr, start, stop, zero, one_shot;
  logic [W-1:0] limit, count, load_val;
  logic         load;
  logic         cnt_en, cnt_clr_n, done;
  logic [1:0]   state;

  int checks = 0;
  int errors = 0;

  counter_sequencer #(.TICK_DIV(TD), .CNT_WIDTH(W)) dut (
    .clk(clk), .clr(clr), .start(start), .stop(stop), .zero(zero),
    .one_shot(one_shot), .limit(limit), .count(count),
    .cnt_en(cnt_en), .cnt_clr_n(cnt_clr_n), .state(state), .done(done)
  );

  always #5 clk = ~clk;

  // Counter being controlled: async clear, enable-gated increment, bench preload.
  always @(posedge clk or negedge cnt_clr_n) begin
    if (!cnt_clr_n)  count <= '0;
    else if (load)   count <= load_val;
    else if (cnt_en) count <= count + 1'b1;
  end

  // Reference model: commands take effect one cycle after their rise is seen;
  // a pulse is due whenever the number of cycles spent staying in RUN since
  // the last restart reaches a multiple of TD.
  typedef struct packed {
    logic [1:0]  st;
    int unsigned tk;
    logic        en;
  } mstep_t;

  mstep_t     ms;
  logic       m_clrn;
  logic [2:0] m_lv, m_pend;  // {zero, stop, start}

  function automatic mstep_t model_step(mstep_t cur, logic [2:0] pend, logic os, logic at_lim);
    mstep_t r;
    r    = cur;
    r.en = 1'b0;
    if (pend[2]) begin
      r.st = 2'b00;
      r.tk = 0;
    end else if (cur.st == 2'b00) begin
      if (pend[0]) begin r.st = 2'b01; r.tk = 0; end
    end else if (cur.st == 2'b10) begin
      if (pend[0]) r.st = 2'b01;
    end else if (cur.st == 2'b01) begin
      if (pend[1])              r.st = 2'b10;
      else if (os && at_lim)    r.st = 2'b11;
      else begin
        r.tk = cur.tk + 1;
        r.en = ((r.tk % TD) == 0);
      end
    end
    return r;
  endfunction

  always @(posedge clk or negedge clr) begin
    if (!clr) begin
      ms     <= '0;
      m_clrn <= 1'b0;
      m_lv   <= '0;
      m_pend <= '0;
    end else begin
      ms     <= model_step(ms, m_pend, one_shot, count == limit);
      m_clrn <= ~m_pend[2];
      m_pend <= {zero, stop, start} & ~m_lv;
      m_lv   <= {zero, stop, start};
    end
  end

  logic [4:0] d_out, m_out;
  assign d_out = {state, cnt_en, cnt_clr_n, done};
  assign m_out = {ms.st, ms.en, m_clrn, ms.st == 2'b11};

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (d_out !== 5'b00000) begin errors++; $display("FAIL reset_outputs: got %b want 00000", d_out); end
    checks++;
    if (count !== 8'h00) begin errors++; $display("FAIL reset_count: got %h want 00", count); end
    clr = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (cnt_clr_n !== 1'b1 || state !== 2'b00) begin
      errors++; $display("FAIL reset_release: clr_n=%b state=%b want 1/00", cnt_clr_n, state);
    end
  endtask

  task automatic test_held_level();
    int entry;
    @(negedge clk); clr = 1'b0; start = 1'b1;
    repeat (2) @(negedge clk);
    clr = 1'b1;
    entry = -1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (d_out !== m_out) begin errors++; $display("FAIL held_model: dut=%b model=%b", d_out, m_out); end
      if (entry < 0 && state == 2'b01) entry = i;
    end
    checks++;
    if (entry != 1) begin errors++; $display("FAIL held_entry: got cycle %0d want 1", entry); end
    stop = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); stop = 1'b0;
      checks++;
      if (d_out !== m_out) begin errors++; $display("FAIL held_pause_model: dut=%b model=%b", d_out, m_out); end
    end
    checks++;
    if (state !== 2'b10) begin errors++; $display("FAIL held_no_repeat: state=%b want 10", state); end
    start = 1'b0; zero = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); zero = 1'b0;
    end
    checks++;
    if (state !== 2'b00 || count !== 8'h00) begin
      errors++; $display("FAIL held_cleanup: state=%b count=%h want 00/00", state, count);
    end
  endtask

  task automatic test_free_run();
    int entry, first, npulse;
    one_shot = 1'b0; limit = 8'hFF;
    @(negedge clk); start = 1'b1;
    entry = -1; first = -1; npulse = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); start = 1'b0;
      checks++;
      if (d_out !== m_out) begin errors++; $display("FAIL free_run_model: dut=%b model=%b", d_out, m_out); end
      if (entry < 0 && state == 2'b01) entry = i;
      if (entry >= 0) begin
        if (cnt_en) begin npulse++; if (first < 0) first = i - entry; end
        if (i - entry == 13) break;
      end
    end
    checks++;
    if (entry != 1) begin errors++; $display("FAIL free_run_latency: got %0d want 1", entry); end
    checks++;
    if (first != TD) begin errors++; $display("FAIL free_run_first_pulse: got %0d want %0d", first, TD); end
    checks++;
    if (npulse != 3 || count !== 8'd3 || state !== 2'b01) begin
      errors++; $display("FAIL free_run_count: pulses=%0d count=%0d state=%b want 3/3/01", npulse, count, state);
    end
  endtask

  task automatic test_pause();
    bit ok;
    int npulse, re, gap;
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (cnt_en && count == 8'd4) begin ok = 1; break; end
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL pause_sync: no pulse with count=4 seen, got count=%0d", count); end
    @(negedge clk);
    stop = 1'b1;  // prescaler phase 1 now, held at 2 once PAUSE is reached
    npulse = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); stop = 1'b0;
      checks++;
      if (d_out !== m_out) begin errors++; $display("FAIL pause_model: dut=%b model=%b", d_out, m_out); end
      if (cnt_en) npulse++;
    end
    checks++;
    if (state !== 2'b10 || npulse != 0 || count !== 8'd5) begin
      errors++; $display("FAIL pause_hold: state=%b pulses=%0d count=%0d want 10/0/5", state, npulse, count);
    end
    start = 1'b1;
    re = -1; gap = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); start = 1'b0;
      checks++;
      if (d_out !== m_out) begin errors++; $display("FAIL resume_model: dut=%b model=%b", d_out, m_out); end
      if (re < 0 && state == 2'b01) re = i;
      if (re >= 0 && cnt_en) begin gap = i - re; break; end
    end
    checks++;
    if (gap != 2) begin errors++; $display("FAIL resume_phase: pulse after %0d cycles want 2", gap); end
    @(negedge clk);
    checks++;
    if (count !== 8'd6) begin errors++; $display("FAIL resume_count: got %0d want 6", count); end
  endtask

  task automatic test_one_shot(input int unsigned lim, input int unsigned tries);
    int npulse, lows;
    @(negedge clk); zero = 1'b1; lows = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); zero = 1'b0;
      if (!cnt_clr_n) lows++;
    end
    checks++;
    if (lows != 1 || count !== 8'd0 || state !== 2'b00) begin
      errors++; $display("FAIL one_shot_clear: lows=%0d count=%0d state=%b want 1/0/00", lows, count, state);
    end
    one_shot = 1'b1; limit = W'(lim); start = 1'b1; npulse = 0;
    for (int i = 0; i < int'((lim + 2) * TD + 8); i++) begin
      @(negedge clk); start = 1'b0;
      checks++;
      if (d_out !== m_out) begin errors++; $display("FAIL one_shot_model: dut=%b model=%b", d_out, m_out); end
      if (cnt_en) npulse++;
    end
    checks++;
    if (npulse != int'(lim) || count !== W'(lim) || state !== 2'b11 || done !== 1'b1) begin
      errors++;
      $display("FAIL one_shot_limit%0d: pulses=%0d count=%0d state=%b done=%b want %0d/%0d/11/1",
               lim, npulse, count, state, done, lim, lim);
    end
    npulse = 0;
    for (int i = 0; i < int'(tries); i++) begin
      @(negedge clk);
      start = i[0]; stop = i[1];
      if (cnt_en) npulse++;
    end
    start = 1'b0; stop = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (npulse != 0 || count !== W'(lim) || state !== 2'b11) begin
      errors++; $display("FAIL done_ignores: pulses=%0d count=%0d state=%b want 0/%0d/11", npulse, count, state, lim);
    end
  endtask

  task automatic test_zero_priority();
    int lows, npulse;
    @(negedge clk); zero = 1'b1;
    @(negedge clk); zero = 1'b0;
    repeat (2) @(negedge clk);
    one_shot = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat ($urandom_range(6, 20)) @(negedge clk);
    stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (state !== 2'b10) begin errors++; $display("FAIL prio_setup: state=%b want 10", state); end
    zero = 1'b1; start = 1'b1;
    lows = 0; npulse = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); zero = 1'b0; start = 1'b0;
      checks++;
      if (d_out !== m_out) begin errors++; $display("FAIL prio_model: dut=%b model=%b", d_out, m_out); end
      if (!cnt_clr_n) lows++;
      if (cnt_en) npulse++;
    end
    checks++;
    if (lows != 1 || state !== 2'b00 || count !== 8'd0 || npulse != 0) begin
      errors++; $display("FAIL prio_zero_wins: lows=%0d state=%b count=%0d pulses=%0d want 1/00/0/0",
                         lows, state, count, npulse);
    end
  endtask

  task automatic test_reset_mid_run();
    bit ok;
    one_shot = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cnt_en) begin ok = 1; break; end
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL abort_sync: no cnt_en within 20 cycles"); end
    #2 clr = 1'b0;
    #1;
    checks++;
    if (cnt_en !== 1'b0 || cnt_clr_n !== 1'b0 || state !== 2'b00) begin
      errors++; $display("FAIL abort_immediate: en=%b clr_n=%b state=%b want 0/0/00", cnt_en, cnt_clr_n, state);
    end
    @(negedge clk);
    checks++;
    if (count !== 8'd0) begin errors++; $display("FAIL abort_count: got %0d want 0", count); end
    clr = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (cnt_clr_n !== 1'b1) begin errors++; $display("FAIL abort_release: clr_n=%b want 1", cnt_clr_n); end
    repeat (2) @(negedge clk);
    load = 1'b1; load_val = 8'hFF; start = 1'b1;
    @(negedge clk); load = 1'b0; start = 1'b0;
    checks++;
    if (count !== 8'hFF) begin errors++; $display("FAIL wrap_preload: got %h want ff", count); end
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (d_out !== m_out) begin errors++; $display("FAIL wrap_model: dut=%b model=%b", d_out, m_out); end
      if (count == 8'h00) begin ok = 1; break; end
    end
    checks++;
    if (!ok || state !== 2'b01) begin
      errors++; $display("FAIL wrap_free_run: count=%h state=%b want 00/01", count, state);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      checks++;
      if (d_out !== m_out) begin errors++; $display("FAIL random_model: cycle %0d dut=%b model=%b", i, d_out, m_out); end
      start = ($urandom_range(0, 5) == 0);
      stop  = ($urandom_range(0, 9) == 0);
      zero  = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 49) == 0) one_shot = ~one_shot;
      if ($urandom_range(0, 49) == 0) limit = W'($urandom_range(0, 31));
    end
    start = 1'b0; stop = 1'b0; zero = 1'b0;
  endtask

  initial begin
    clr = 1'b1; start = 1'b0; stop = 1'b0; zero = 1'b0;
    one_shot = 1'b0; limit = '0; load = 1'b0; load_val = '0;
    #1 clr = 1'b0;
    test_reset();
    test_held_level();
    test_free_run();
    test_pause();
    test_one_shot(3, 12);
    test_one_shot(0, 6);
    for (int k = 0; k < 3; k++) test_one_shot($urandom_range(1, 6), 4);
    test_zero_priority();
    test_reset_mid_run();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/counter_sequencer.md
Name: counter_sequencer

Overview:
Run/pause/clear controller for the 8-bit enable-gated ripple-toggle counter that drives the HEX display pair. It turns three push-button/switch commands into a prescaled one-cycle count-enable and a one-cycle active-low clear for that counter. It also supports free-run or one-shot counting up to a programmable limit, using the counter's output as feedback. It sits between the board inputs and the counter.

Parameters:
TICK_DIV, 50000000, clk cycles per count-enable pulse (must be >= 2; benches use 4)
CNT_WIDTH, 8, width of the counter value and limit

Ports:
clk  in  1  system clock, rising edge
clr  in  1  asynchronous active-low reset
start  in  1  run request, level; action on rising edge
stop  in  1  pause request, level; action on rising edge
zero  in  1  clear request, level; action on rising edge
one_shot  in  1  1 = stop at limit, 0 = free-run with wrap
limit  in  CNT_WIDTH  terminal count for one-shot mode
count  in  CNT_WIDTH  current counter value (feedback)
cnt_en  out  1  count-enable to counter, one-cycle pulse
cnt_clr_n  out  1  active-low clear to counter, one-cycle pulse
state  out  2  IDLE=00, RUN=01, PAUSE=10, DONE=11
done  out  1  high while state==DONE

Behaviour:
- Reset (clr=0, asynchronous):
  - state=IDLE, prescaler=0, cnt_en=0, edge registers=0, done=0.
  - cnt_clr_n=0, so the counter is held cleared throughout reset.
  - cnt_clr_n rises to 1 on the first clk edge after clr deasserts.
- Edge detect:
  - Each of start/stop/zero is registered once; rise = in & ~in_q.
  - A level held high through reset release counts as one rise.
  - A held level never repeats the rise.
- Command priority within a cycle: zero > stop > start > limit-reached.
- The zero rise in any state:
  - Next cycle: cnt_clr_n=0 for exactly one cycle.
  - state becomes IDLE and the prescaler clears to 0.
- IDLE:
  - A start rise moves to RUN with the prescaler at 0.
  - stop is ignored.
- RUN:
  - The prescaler counts 0..TICK_DIV-1 and wraps.
  - In the cycle after the prescaler equals TICK_DIV-1, cnt_en=1 for one cycle.
  - The first pulse comes TICK_DIV cycles after entry from IDLE.
  - A stop rise moves to PAUSE. No cnt_en is issued from the cycle state leaves RUN.
- PAUSE:
  - The prescaler holds its value and cnt_en=0.
  - A start rise returns to RUN and resumes the prescaler from the held phase.
- One-shot limit:
  - Applies when state==RUN, one_shot=1 and count==limit.
  - Next state is DONE, and cnt_en is suppressed in that same cycle.
  - If count==limit on entry to RUN, DONE is entered with zero pulses issued.
  - The compare uses count at least one cycle after each pulse (TICK_DIV>=2 guarantees this), so there is no overshoot.
- DONE:
  - cnt_en=0 and done=1.
  - start and stop are ignored; only a zero rise (or reset) exits.
- Free-run (one_shot=0): the counter wraps all-ones to 0 with no state change. Toggling one_shot while in RUN takes effect on the next compare.
- Latency:
  - Command input to state change: 2 cycles (edge register plus state register).
  - zero input to cnt_clr_n low: 2 cycles.
- Outputs cnt_en and cnt_clr_n are registered (glitch-free), since the counter clear is asynchronous.
- Reset mid-RUN aborts immediately; no partial pulse appears on cnt_en.

Test Plan:
1. TICK_DIV=4, one_shot=0, pulse start → state=01; cnt_en high 1 cycle every 4 clks; first pulse 4 clks after RUN entry; counter model reaches 3 after 12 clks in RUN.
2. RUN, count=5, pulse stop mid-prescale (phase 2) → state=10, no cnt_en; pulse start → next cnt_en exactly 2 clks after RUN re-entry, count=6.
3. one_shot=1, limit=3, start from count=0 → exactly 3 cnt_en pulses; state=11 and done=1 while count=3; further start rises leave count=3.
4. one_shot=1, limit=0, count=0, start → DONE with zero cnt_en pulses.
5. Same cycle rises on zero and start while in PAUSE → cnt_clr_n low exactly 1 cycle, state=00, count=0, no cnt_en.
6. Assert clr low mid-RUN between pulses → cnt_en=0 and cnt_clr_n=0 immediately, state=00; release → cnt_clr_n=1 after one clk; free-run from 0xFF wraps to 0x00 with state still 01.
